// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
// Shares one 35x35 signed multiplier among NCH requesting channels. Requests
// are granted round-robin, at most one issue every GAP cycles. A small tag
// FIFO remembers which channel owns each in-flight product so that results
// can be routed back in issue order.
module mul_share_arbiter #(
  parameter int NCH       = 4,
  parameter int GAP       = 4,
  parameter int TAG_DEPTH = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NCH-1:0]            i_req,
  input  logic [NCH*35-1:0]         i_a,
  input  logic [NCH*35-1:0]         i_b,
  output logic [NCH-1:0]            o_gnt,
  output logic                      o_mul_en,
  output logic signed [34:0]        o_mul_a,
  output logic signed [34:0]        o_mul_b,
  input  logic signed [68:0]        i_mul_c,
  input  logic                      i_mul_c_en,
  output logic signed [68:0]        o_res,
  output logic [$clog2(NCH)-1:0]    o_res_ch,
  output logic                      o_res_vld,
  output logic                      o_busy,
  output logic                      o_err
);

  localparam int CW = $clog2(NCH);
  localparam int SW = $clog2(GAP);
  localparam int AW = $clog2(TAG_DEPTH);

  localparam logic [SW-1:0] SLOT_LOAD = SW'(GAP - 1);
  localparam logic [SW-1:0] SLOT_ONE  = SW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(TAG_DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CH_ONE    = CW'(1);
  localparam logic [CW-1:0] CH_LAST   = CW'(NCH - 1);
  localparam logic [CW:0]   CH_WRAP   = (CW + 1)'(NCH);

  // Unpacked per-channel operands
  logic signed [34:0] a_ch [NCH];
  logic signed [34:0] b_ch [NCH];

  // Round-robin search: requests rotated so that bit 0 is the channel at the pointer
  logic [2*NCH-1:0]   req_dbl;
  logic [NCH-1:0]     req_rot;
  logic [CW-1:0]      cand_idx [NCH];
  logic               win_found;
  logic [CW-1:0]      win_idx;

  // Issue slot and round-robin state
  logic [SW-1:0]      slot_cnt_reg;
  logic [SW-1:0]      slot_cnt_next;
  logic [CW-1:0]      rr_ptr_reg;
  logic [CW-1:0]      rr_ptr_next;

  // Tag FIFO
  logic [CW-1:0]      tag_mem [TAG_DEPTH];
  logic [AW-1:0]      wr_ptr_reg;
  logic [AW-1:0]      rd_ptr_reg;
  logic [AW:0]        count_reg;
  logic [AW:0]        count_next;

  // Decisions for the current edge
  logic               slot_free;
  logic               fifo_full;
  logic               fifo_empty;
  logic               issue;
  logic               pop;
  logic [NCH-1:0]     gnt_next;
  logic               busy_next;

  // Registered outputs
  logic [NCH-1:0]     gnt_reg;
  logic               mul_en_reg;
  logic signed [34:0] mul_a_reg;
  logic signed [34:0] mul_b_reg;
  logic signed [68:0] res_reg;
  logic [CW-1:0]      res_ch_reg;
  logic               res_vld_reg;
  logic               busy_reg;
  logic               err_reg;

  assign req_dbl = {i_req, i_req} >> rr_ptr_reg;
  assign req_rot = req_dbl[NCH-1:0];

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    logic [CW:0] cand_sum;

    assign a_ch[gi]     = i_a[35*gi +: 35];
    assign b_ch[gi]     = i_b[35*gi +: 35];
    // Absolute channel number of rotated position gi, wrapped modulo NCH
    assign cand_sum     = {1'b0, rr_ptr_reg} + (CW + 1)'(gi);
    assign cand_idx[gi] = (cand_sum >= CH_WRAP) ? CW'(cand_sum - CH_WRAP) : cand_sum[CW-1:0];
    assign gnt_next[gi] = issue && (win_idx == CW'(gi));
  end

  // Pick the first requesting channel at or after the round-robin pointer
  always_comb begin
    win_found = |req_rot;
    win_idx   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        win_idx = cand_idx[i];
      end
    end
  end

  assign slot_free  = (slot_cnt_reg == '0);
  assign fifo_full  = (count_reg == CNT_FULL);
  assign fifo_empty = (count_reg == '0);
  assign issue      = slot_free && !fifo_full && win_found;
  assign pop        = i_mul_c_en && !fifo_empty;

  // Next-state for slot counter, pointer, FIFO occupancy and busy flag
  always_comb begin
    slot_cnt_next = slot_cnt_reg;
    if (issue) begin
      slot_cnt_next = SLOT_LOAD;
    end else if (!slot_free) begin
      slot_cnt_next = slot_cnt_reg - SLOT_ONE;
    end

    rr_ptr_next = rr_ptr_reg;
    if (issue) begin
      rr_ptr_next = (win_idx == CH_LAST) ? '0 : win_idx + CH_ONE;
    end

    count_next = count_reg;
    case ({issue, pop})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase

    busy_next = (slot_cnt_next != '0) || (count_next != '0);
  end

  // Control state: slot timer, round-robin pointer, FIFO pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot_cnt_reg <= '0;
      rr_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      busy_reg     <= 1'b0;
    end else begin
      slot_cnt_reg <= slot_cnt_next;
      rr_ptr_reg   <= rr_ptr_next;
      count_reg    <= count_next;
      busy_reg     <= busy_next;
      if (issue) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
    end
  end

  // Tag storage; no reset needed since the pointers define validity
  always_ff @(posedge i_clk) begin
    if (issue) begin
      tag_mem[wr_ptr_reg] <= win_idx;
    end
  end

  // Issue side: grant pulse, multiplier strobe and held operands
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      gnt_reg    <= '0;
      mul_en_reg <= 1'b0;
      mul_a_reg  <= '0;
      mul_b_reg  <= '0;
    end else begin
      gnt_reg    <= gnt_next;
      mul_en_reg <= issue;
      if (issue) begin
        mul_a_reg <= a_ch[win_idx];
        mul_b_reg <= b_ch[win_idx];
      end
    end
  end

  // Return side: route each product to the oldest tag; flag orphan products
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      res_reg     <= '0;
      res_ch_reg  <= '0;
      res_vld_reg <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      res_vld_reg <= pop;
      if (pop) begin
        res_reg    <= i_mul_c;
        res_ch_reg <= tag_mem[rd_ptr_reg];
      end
      if (i_mul_c_en && fifo_empty) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign o_gnt     = gnt_reg;
  assign o_mul_en  = mul_en_reg;
  assign o_mul_a   = mul_a_reg;
  assign o_mul_b   = mul_b_reg;
  assign o_res     = res_reg;
  assign o_res_ch  = res_ch_reg;
  assign o_res_vld = res_vld_reg;
  assign o_busy    = busy_reg;
  assign o_err     = err_reg;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter
// Randomized bench with a transaction-level reference: issue times come from
// the last issue time plus GAP, the winner is the requester at the smallest
// round-robin distance from the pointer, and in-flight owners live in a queue.
// A behavioural multiplier returns products after a per-phase latency.
module tb_mul_share_arbiter;

  localparam int NCH       = 4;
  localparam int GAP       = 4;
  localparam int TAG_DEPTH = 4;

  localparam int MODE_IDLE    = 0;
  localparam int MODE_ONESHOT = 1;
  localparam int MODE_CONT    = 2;
  localparam int MODE_RAND    = 3;

  logic                  clk;
  logic                  rst_n;
  logic [NCH-1:0]        req;
  logic [NCH*35-1:0]     a_bus;
  logic [NCH*35-1:0]     b_bus;
  logic [NCH-1:0]        gnt;
  logic                  mul_en;
  logic signed [34:0]    mul_a;
  logic signed [34:0]    mul_b;
  logic signed [68:0]    mul_c;
  logic                  mul_c_en;
  logic signed [68:0]    res;
  logic [1:0]            res_ch;
  logic                  res_vld;
  logic                  busy;
  logic                  err;

  mul_share_arbiter #(
    .NCH       (NCH),
    .GAP       (GAP),
    .TAG_DEPTH (TAG_DEPTH)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req      (req),
    .i_a        (a_bus),
    .i_b        (b_bus),
    .o_gnt      (gnt),
    .o_mul_en   (mul_en),
    .o_mul_a    (mul_a),
    .o_mul_b    (mul_b),
    .i_mul_c    (mul_c),
    .i_mul_c_en (mul_c_en),
    .o_res      (res),
    .o_res_ch   (res_ch),
    .o_res_vld  (res_vld),
    .o_busy     (busy),
    .o_err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int                 due;
    logic signed [68:0] val;
  } prod_t;

  // Reference model state
  prod_t              prodq[$];
  int                 tagq[$];
  int                 t;
  int                 next_ok;
  int                 ptr;
  int                 lat;
  int                 mode;
  bit                 stray;
  logic signed [34:0] opa [NCH];
  logic signed [34:0] opb [NCH];
  logic [NCH-1:0]     exp_gnt;
  logic               exp_mul_en;
  logic signed [34:0] exp_mul_a;
  logic signed [34:0] exp_mul_b;
  logic signed [68:0] exp_res;
  int                 exp_res_ch;
  logic               exp_res_vld;
  logic               exp_busy;
  logic               exp_err;
  logic signed [68:0] last_res;
  logic [1:0]         last_res_ch;

  int checks;
  int errors;

  task automatic check(input string tag, input logic [68:0] got, input logic [68:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, expv, t);
    end
  endtask

  function automatic logic signed [34:0] rnd35();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    case ($urandom_range(0, 7))
      0:       return 35'h4_0000_0000;
      1:       return 35'h3_FFFF_FFFF;
      default: return r[34:0];
    endcase
  endfunction

  // One clock: drive inputs, predict, clock, compare, then update stimulus
  task automatic step();
    bit                 issue;
    bit                 pop;
    int                 win;
    int                 best;
    int                 d;
    logic signed [68:0] ea;
    logic signed [68:0] eb;
    logic [95:0]        junk;

    for (int k = 0; k < NCH; k++) begin
      a_bus[35*k +: 35] = opa[k];
      b_bus[35*k +: 35] = opb[k];
    end
    junk     = {$urandom(), $urandom(), $urandom()};
    mul_c    = junk[68:0];
    mul_c_en = 1'b0;
    if (prodq.size() > 0 && prodq[0].due == t) begin
      mul_c_en = 1'b1;
      mul_c    = prodq[0].val;
      void'(prodq.pop_front());
    end else if (stray && $urandom_range(0, 3) == 0) begin
      mul_c_en = 1'b1;
    end

    // Prediction for this edge
    issue = (t >= next_ok) && (tagq.size() < TAG_DEPTH) && (req != '0);
    win   = -1;
    best  = NCH;
    if (issue) begin
      for (int k = 0; k < NCH; k++) begin
        if (req[k]) begin
          d = (k - ptr + NCH) % NCH;
          if (d < best) begin
            best = d;
            win  = k;
          end
        end
      end
    end
    exp_gnt     = '0;
    exp_mul_en  = issue;
    exp_res_vld = 1'b0;
    pop = mul_c_en && (tagq.size() > 0);
    if (pop) begin
      exp_res_vld = 1'b1;
      exp_res     = mul_c;
      exp_res_ch  = tagq.pop_front();
    end else if (mul_c_en) begin
      exp_err = 1'b1;
    end
    if (issue) begin
      exp_gnt[win] = 1'b1;
      tagq.push_back(win);
      ptr       = (win + 1) % NCH;
      next_ok   = t + GAP;
      exp_mul_a = opa[win];
      exp_mul_b = opb[win];
      ea        = opa[win];
      eb        = opb[win];
      prodq.push_back('{due: t + lat, val: ea * eb});
    end
    exp_busy = (next_ok > t + 1) || (tagq.size() > 0);

    @(posedge clk);
    @(negedge clk);

    check("gnt", gnt, exp_gnt);
    check("mul_en", mul_en, exp_mul_en);
    check("mul_a", mul_a, exp_mul_a);
    check("mul_b", mul_b, exp_mul_b);
    check("res_vld", res_vld, exp_res_vld);
    check("busy", busy, exp_busy);
    check("err", err, exp_err);
    if (exp_res_vld) begin
      check("res", res, exp_res);
      check("res_ch", res_ch, exp_res_ch);
    end
    if (res_vld) begin
      last_res    = res;
      last_res_ch = res_ch;
    end
    $display("edge %0d req=%b gnt=%b mul_en=%0d c_en=%0d res_vld=%0d res_ch=%0d busy=%0d err=%0d",
             t, req, gnt, mul_en, mul_c_en, res_vld, res_ch, busy, err);
    t++;

    // Stimulus update: served channels get fresh operands; others may come and go
    for (int k = 0; k < NCH; k++) begin
      if (exp_gnt[k]) begin
        opa[k] = rnd35();
        opb[k] = rnd35();
        req[k] = (mode == MODE_CONT) || (mode == MODE_RAND && $urandom_range(0, 1) == 1);
      end else if (mode == MODE_RAND) begin
        if (!req[k]) begin
          if ($urandom_range(0, 3) == 0) begin
            opa[k] = rnd35();
            opb[k] = rnd35();
            req[k] = 1'b1;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req[k] = 1'b0;
        end
      end
    end
  endtask

  // Withdraw all requests and let every in-flight product come home
  task automatic drain();
    int g;
    mode = MODE_IDLE;
    req  = '0;
    g    = 0;
    while ((prodq.size() > 0 || tagq.size() > 0) && g < 200) begin
      step();
      g++;
    end
    check("drain_empty", tagq.size(), 0);
    repeat (GAP) step();
  endtask

  // Asynchronous reset starting just after a falling edge
  task automatic apply_reset(input int ncyc);
    #2;
    rst_n    = 1'b0;
    req      = '0;
    mul_c_en = 1'b0;
    mode     = MODE_IDLE;
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_mul_en", mul_en, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    check("rst_res", res, 0);
    check("rst_res_ch", res_ch, 0);
    check("rst_res_vld", res_vld, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    tagq.delete();
    next_ok     = 0;
    ptr         = 0;
    exp_gnt     = '0;
    exp_mul_en  = 1'b0;
    exp_mul_a   = '0;
    exp_mul_b   = '0;
    exp_res_vld = 1'b0;
    exp_busy    = 1'b0;
    exp_err     = 1'b0;
    repeat (ncyc) @(posedge clk);
    @(negedge clk);
    t += ncyc;
    rst_n = 1'b1;
  endtask

  task automatic new_ops_all();
    for (int k = 0; k < NCH; k++) begin
      opa[k] = rnd35();
      opb[k] = rnd35();
    end
  endtask

  initial begin
    int g;
    checks   = 0;
    errors   = 0;
    t        = 0;
    lat      = 8;
    stray    = 1'b0;
    mode     = MODE_IDLE;
    rst_n    = 1'b1;
    req      = '0;
    mul_c    = '0;
    mul_c_en = 1'b0;
    a_bus    = '0;
    b_bus    = '0;
    for (int k = 0; k < NCH; k++) begin
      opa[k] = '0;
      opb[k] = '0;
    end
    apply_reset(3);

    // Single request on channel 2, product after 8 cycles
    last_res    = '0;
    last_res_ch = '0;
    mode   = MODE_ONESHOT;
    lat    = 8;
    opa[2] = 35'sd3;
    opb[2] = -35'sd5;
    req    = 4'b0100;
    repeat (14) step();
    check("single_res", last_res, -15);
    check("single_ch", last_res_ch, 2);
    drain();

    // All channels requesting continuously, short latency
    new_ops_all();
    mode = MODE_CONT;
    lat  = 3;
    req  = '1;
    repeat (40) step();
    drain();

    // Long latency: tag FIFO fills and grants stall
    new_ops_all();
    mode = MODE_CONT;
    lat  = 20;
    req  = '1;
    repeat (80) step();
    drain();

    // Latency equal to GAP: pop and push land on the same edge
    new_ops_all();
    mode = MODE_CONT;
    lat  = GAP;
    req  = '1;
    repeat (30) step();
    drain();

    // Random request patterns, withdrawals and latencies
    for (int r = 0; r < 4; r++) begin
      mode = MODE_RAND;
      lat  = $urandom_range(1, 24);
      repeat (150) step();
      drain();
    end

    // Operand extremes
    last_res = '0;
    mode   = MODE_ONESHOT;
    lat    = 5;
    opa[1] = 35'h4_0000_0000;
    opb[1] = 35'h4_0000_0000;
    req    = 4'b0010;
    repeat (12) step();
    check("ext_neg_sq", last_res, 69'h10_0000_0000_0000_0000);
    last_res = '0;
    opa[1] = 35'h3_FFFF_FFFF;
    opb[1] = 35'h4_0000_0000;
    req    = 4'b0010;
    repeat (12) step();
    check("ext_mixed", last_res, 69'h10_0000_0004_0000_0000);
    drain();

    // Reset with two products in flight; their late arrival is an error
    new_ops_all();
    mode = MODE_CONT;
    lat  = 20;
    req  = '1;
    g    = 0;
    while (tagq.size() < 2 && g < 40) begin
      step();
      g++;
    end
    check("inflight_two", tagq.size(), 2);
    apply_reset(2);
    repeat (30) step();
    check("orphan_err", err, 1);

    // Stray product strobes with nothing in flight
    stray = 1'b1;
    repeat (20) step();
    stray = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
